// File: rtl/kianv_uart_pkg.sv
// ---------------------------------------------------------------------------
// kianv_uart_pkg
// Shared definitions for the UART front ends.
//   rx_state_t      : receiver FSM states (IDLE, START, DATA, STOP, BREAK)
//   DIV_MIN         : smallest usable bit-period divisor; smaller values clamp
//   FRAME_DATA_BITS : data bits per 8N1 frame
//   FRAME_STOP_BITS : stop bits per 8N1 frame
// ---------------------------------------------------------------------------
package kianv_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    localparam int DIV_MIN         = 2;
    localparam int FRAME_DATA_BITS = 8;
    localparam int FRAME_STOP_BITS = 1;

endpackage

// File: rtl/uart_rx_fifo_feeder_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Generic two-flop synchronizer for a single asynchronous input.
//   clk    : destination clock
//   resetn : asynchronous active-low reset; both flops load RESET_VALUE
//   d      : asynchronous input
//   q      : synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_feeder.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_feeder
// 8N1 UART receiver that pushes each good byte into a downstream FIFO.
//   clk       : system clock
//   resetn    : asynchronous active-low reset
//   rx        : raw serial line (asynchronous, idle high)
//   div       : clk cycles per bit, latched at start-bit detection (0/1 -> 2)
//   dout      : received byte, valid while push=1, held until the next push
//   push      : one-cycle FIFO write strobe
//   full      : FIFO full flag, looked at only in the stop-sample cycle
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, good byte dropped because full=1
//   busy      : high whenever the receiver is not idle
//   state     : current FSM state, exported for debug/checkers
//
// Handshake: push is a write strobe with no back-pressure; a byte is offered
// only when full=0 in the stop-sample cycle, otherwise it is dropped and
// overrun pulses instead.
// ---------------------------------------------------------------------------
module uart_rx_fifo_feeder
    import kianv_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rx,
    input  logic [DIV_WIDTH-1:0]  div,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  push,
    input  logic                  full,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy,
    output rx_state_t             state
);

    localparam logic [DIV_WIDTH-1:0] DIV_FLOOR = DIV_WIDTH'(DIV_MIN);
    localparam logic [2:0]           LAST_IDX  = 3'(FRAME_DATA_BITS - 1);

    logic                  rx_s;
    rx_state_t             state_n;
    logic [DIV_WIDTH-1:0]  div_c;
    logic [DIV_WIDTH-1:0]  div_l, div_l_n;
    logic [DIV_WIDTH-1:0]  cnt, cnt_n;
    logic [2:0]            idx, idx_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic [DATA_WIDTH-1:0] dout_n;
    logic                  push_n, frame_err_n, overrun_n;

    sync2 #(.RESET_VALUE(1'b1)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (rx),
        .q      (rx_s)
    );

    assign div_c = (div < DIV_FLOOR) ? DIV_FLOOR : div;
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            div_l     <= DIV_FLOOR;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            dout      <= '0;
            push      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            div_l     <= div_l_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            dout      <= dout_n;
            push      <= push_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    // cnt holds the number of cycles left before the next sample; a sample
    // happens in the cycle where cnt reaches zero.
    always_comb begin
        state_n     = state;
        div_l_n     = div_l;
        cnt_n       = cnt;
        idx_n       = idx;
        shreg_n     = shreg;
        dout_n      = dout;
        push_n      = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    // First sample lands half a bit after detection.
                    div_l_n = div_c;
                    cnt_n   = (div_c >> 1) - 1'b1;
                    state_n = ST_START;
                end
            end

            ST_START: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        idx_n   = '0;
                        cnt_n   = div_l - 1'b1;
                        state_n = ST_DATA;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt == '0) begin
                    // LSB arrives first, so shifting in from the top leaves
                    // bit 0 in place after the eighth sample.
                    shreg_n = {rx_s, shreg[DATA_WIDTH-1:1]};
                    cnt_n   = div_l - 1'b1;
                    if (idx == LAST_IDX) begin
                        state_n = ST_STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt == '0) begin
                    if (rx_s) begin
                        if (!full) begin
                            push_n = 1'b1;
                            dout_n = shreg;
                        end else begin
                            overrun_n = 1'b1;
                        end
                        state_n = ST_IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = ST_BREAK;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            ST_BREAK: begin
                // Hold off until the line idles so a stuck-low line is not
                // decoded as a string of zero bytes.
                if (rx_s) begin
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
